// File: rtl/sprite_anim_lut_pkg.sv
// Shared types for the animated sprite store: pixel type, animation mode and sequencer states.
package sprite_pkg;

    localparam int SPRITE_BPP = 3;

    typedef logic [SPRITE_BPP-1:0] pixel_t;

    localparam pixel_t PIX_TRANSPARENT = '0;

    typedef enum logic {
        ANIM_LOOP     = 1'b0,
        ANIM_PINGPONG = 1'b1
    } anim_mode_e;

    typedef enum logic [1:0] {
        PLAY_FWD = 2'd0,
        PLAY_BWD = 2'd1,
        PAUSED   = 2'd2
    } anim_state_e;

    // Index width for a table of v entries, never narrower than one bit.
    function automatic int clog2_min1(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/sprite_anim_lut_if.sv
// Pixel lookup bus: request side (coordinates, mirror) and registered result side.
interface sprite_anim_lut_if #(
    parameter int XW  = 5,
    parameter int YW  = 5,
    parameter int BPP = 3
);
    logic           req_valid;
    logic [XW-1:0]  x;
    logic [YW-1:0]  y;
    logic           mirror;
    logic           pix_valid;
    logic [BPP-1:0] pixel;

    modport master (
        output req_valid, x, y, mirror,
        input  pix_valid, pixel
    );

    modport slave (
        input  req_valid, x, y, mirror,
        output pix_valid, pixel
    );
endinterface

// File: rtl/sprite_anim_lut_seq.sv
// Animation sequencer: hold counter, play direction and displayed frame index.
module sprite_anim_seq
    import sprite_pkg::*;
#(
    parameter int  NFRAMES = 4,
    parameter int  HOLD    = 8,
    parameter int  MODE    = 0,
    localparam int FW      = clog2_min1(NFRAMES),
    localparam int CW      = clog2_min1(HOLD)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          frame_tick,
    input  logic          anim_en,
    input  logic          anim_restart,
    output logic [FW-1:0] frame_idx
);

    anim_state_e   st_q, st_d;
    logic          bwd_q, bwd_d;
    logic          cur_bwd;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [FW-1:0] frm_q, frm_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q  <= PLAY_FWD;
            bwd_q <= 1'b0;
            cnt_q <= '0;
            frm_q <= '0;
        end else begin
            st_q  <= st_d;
            bwd_q <= bwd_d;
            cnt_q <= cnt_d;
            frm_q <= frm_d;
        end
    end

    always_comb begin
        // bwd_q remembers the direction across a pause
        cur_bwd = (st_q == PLAY_BWD) || ((st_q == PAUSED) && bwd_q);
        cnt_d   = cnt_q;
        frm_d   = frm_q;
        bwd_d   = cur_bwd;
        st_d    = st_q;

        if (anim_restart) begin
            cnt_d = '0;
            frm_d = '0;
            bwd_d = 1'b0;
        end else if (frame_tick && anim_en) begin
            if (cnt_q == CW'(HOLD - 1)) begin
                cnt_d = '0;
                if (NFRAMES > 1) begin
                    if (MODE == int'(ANIM_PINGPONG)) begin
                        if (!cur_bwd) begin
                            if (frm_q == FW'(NFRAMES - 1)) begin
                                bwd_d = 1'b1;
                                frm_d = FW'(NFRAMES - 2);
                            end else begin
                                frm_d = frm_q + FW'(1);
                            end
                        end else if (frm_q == '0) begin
                            bwd_d = 1'b0;
                            frm_d = FW'(1);
                        end else begin
                            frm_d = frm_q - FW'(1);
                        end
                    end else begin
                        frm_d = (frm_q == FW'(NFRAMES - 1)) ? '0 : frm_q + FW'(1);
                    end
                end
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end

        if (!anim_en)
            st_d = PAUSED;
        else if (bwd_d)
            st_d = PLAY_BWD;
        else
            st_d = PLAY_FWD;
    end

    assign frame_idx = frm_q;

endmodule

// File: rtl/sprite_frames.svh
// Bitmap contents of every animation frame, as a function of (frame, row, column).
function automatic logic [7:0] sprite_frame_pix(input int f, input int yy, input int xx);
    int v;
    v = (xx + 2 * yy + 3 * f) ^ (xx >> 2);
    return 8'(v);
endfunction

// File: rtl/sprite_anim_lut.sv
// Animated sprite store with one-cycle registered pixel lookup.
// Optional horizontal flip is built only when SPRITE_MIRROR_EN is defined.
module sprite_anim_lut
    import sprite_pkg::*;
#(
    parameter int  W       = 32,
    parameter int  H       = 32,
    parameter int  NFRAMES = 4,
    parameter int  BPP     = 3,
    parameter int  HOLD    = 8,
    parameter int  MODE    = 0,
    localparam int XW      = clog2_min1(W),
    localparam int YW      = clog2_min1(H),
    localparam int FW      = clog2_min1(NFRAMES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_tick,
    input  logic              anim_en,
    input  logic              anim_restart,
    sprite_anim_lut_if.slave  bus,
    output logic [FW-1:0]     frame_idx
);

    `include "sprite_frames.svh"

    logic [BPP-1:0] rom [NFRAMES][H][W];

    for (genvar f = 0; f < NFRAMES; f++) begin : g_frame
        for (genvar r = 0; r < H; r++) begin : g_row
            for (genvar c = 0; c < W; c++) begin : g_col
                assign rom[f][r][c] = BPP'(sprite_frame_pix(f, r, c));
            end
        end
    end

    sprite_anim_seq #(
        .NFRAMES (NFRAMES),
        .HOLD    (HOLD),
        .MODE    (MODE)
    ) u_seq (
        .clk          (clk),
        .rst          (rst),
        .frame_tick   (frame_tick),
        .anim_en      (anim_en),
        .anim_restart (anim_restart),
        .frame_idx    (frame_idx)
    );

    logic           in_range_p0;
    logic [XW-1:0]  xr_p0;
    logic [BPP-1:0] pix_p0;
    logic           vld_p1;
    logic [BPP-1:0] pix_p1;

    // Stage p0: range check on raw coordinates, optional flip, ROM read
    always_comb begin
        in_range_p0 = (int'(bus.x) < W) && (int'(bus.y) < H);
        xr_p0       = bus.x;
`ifdef SPRITE_MIRROR_EN
        if (bus.mirror)
            xr_p0 = XW'(W - 1) - bus.x;
`endif
        pix_p0 = BPP'(PIX_TRANSPARENT);
        if (in_range_p0)
            pix_p0 = rom[frame_idx][bus.y][xr_p0];
    end

`ifndef SPRITE_MIRROR_EN
    logic unused_mirror;
    assign unused_mirror = bus.mirror;
`endif

    // Stage p1: registered result; pixel holds when no request arrives
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1 <= 1'b0;
            pix_p1 <= '0;
        end else begin
            vld_p1 <= bus.req_valid;
            if (bus.req_valid)
                pix_p1 <= pix_p0;
        end
    end

    assign bus.pix_valid = vld_p1;
    assign bus.pixel     = pix_p1;

endmodule

// File: tb/tb_sprite_anim_lut.sv
// Self-checking bench for sprite_anim_lut: loop, ping-pong and W=30 instances against a reference model.
module tb_sprite_anim_lut;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       frame_tick = 1'b0;
    logic       anim_en = 1'b0;
    logic       anim_restart = 1'b0;
    logic [1:0] f0, f1, f2;

    sprite_anim_lut_if #(.XW(5), .YW(5), .BPP(3)) b0 ();
    sprite_anim_lut_if #(.XW(5), .YW(5), .BPP(3)) b1 ();
    sprite_anim_lut_if #(.XW(5), .YW(5), .BPP(3)) b2 ();

    sprite_anim_lut u0 (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .anim_en(anim_en),
        .anim_restart(anim_restart), .bus(b0), .frame_idx(f0)
    );

    sprite_anim_lut #(.MODE(1), .HOLD(1)) u1 (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .anim_en(anim_en),
        .anim_restart(anim_restart), .bus(b1), .frame_idx(f1)
    );

    sprite_anim_lut #(.W(30)) u2 (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .anim_en(anim_en),
        .anim_restart(anim_restart), .bus(b2), .frame_idx(f2)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    int t0 = 0;             // enabled ticks since restart, u0/u2
    int t1 = 0;             // enabled ticks since restart, u1
    int exp0 = 0, exp1 = 0, exp2 = 0;

    // Frame contents: (x + 2y + 3f) xor (x div 4), palette index mod 8
    function automatic int bmp(input int f, input int yy, input int xx);
        return ((xx + 2 * yy + 3 * f) ^ (xx / 4)) % 8;
    endfunction

    function automatic int ref_pix(input int w, input int f, input int xx, input int yy, input bit mr);
        int xe;
        if (xx >= w || yy >= 32)
            return 0;
        xe = xx;
`ifdef SPRITE_MIRROR_EN
        if (mr)
            xe = w - 1 - xx;
`endif
        return bmp(f, yy, xe);
    endfunction

    // Displayed frame after t enabled ticks: step k = t/hold through the mode's sequence
    function automatic int ref_frame(input int t, input int hold, input int mode);
        int k, p, m;
        k = t / hold;
        if (mode == 0)
            return k % 4;
        p = 2 * 4 - 2;
        m = k % p;
        return (m < 4) ? m : p - m;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic drive_bus(input bit rv, input int xx, input int yy, input bit mr);
        b0.req_valid = rv; b0.x = xx[4:0]; b0.y = yy[4:0]; b0.mirror = mr;
        b1.req_valid = rv; b1.x = xx[4:0]; b1.y = yy[4:0]; b1.mirror = mr;
        b2.req_valid = rv; b2.x = xx[4:0]; b2.y = yy[4:0]; b2.mirror = mr;
    endtask

    task automatic cyc(input bit tk, input bit en, input bit rs,
                       input bit rv, input int xx, input int yy, input bit mr);
        int fa0, fa1;
        frame_tick   = tk;
        anim_en      = en;
        anim_restart = rs;
        drive_bus(rv, xx, yy, mr);
        fa0 = ref_frame(t0, 8, 0);
        fa1 = ref_frame(t1, 1, 1);
        if (rv) begin
            exp0 = ref_pix(32, fa0, xx, yy, mr);
            exp1 = ref_pix(32, fa1, xx, yy, mr);
            exp2 = ref_pix(30, fa0, xx, yy, mr);
        end
        @(posedge clk);
        #1;
        if (rs) begin
            t0 = 0;
            t1 = 0;
        end else if (tk && en) begin
            t0++;
            t1++;
        end
        check("frame_loop", 32'(f0), ref_frame(t0, 8, 0));
        check("frame_pingpong", 32'(f1), ref_frame(t1, 1, 1));
        check("frame_w30", 32'(f2), ref_frame(t0, 8, 0));
        check("valid_loop", 32'(b0.pix_valid), 32'(rv));
        check("pixel_loop", 32'(b0.pixel), exp0);
        check("valid_pingpong", 32'(b1.pix_valid), 32'(rv));
        check("pixel_pingpong", 32'(b1.pixel), exp1);
        check("valid_w30", 32'(b2.pix_valid), 32'(rv));
        check("pixel_w30", 32'(b2.pixel), exp2);
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_valid"}, 32'({b0.pix_valid, b1.pix_valid, b2.pix_valid}), 0);
        check({tag, "_pixel"}, 32'({b0.pixel, b1.pixel, b2.pixel}), 0);
        check({tag, "_frame"}, 32'({f0, f1, f2}), 0);
    endtask

    int pp_seq [8] = '{1, 2, 3, 2, 1, 0, 1, 2};

    initial begin
        drive_bus(1'b0, 0, 0, 1'b0);
        #12;
        check_cleared("reset");
        rst = 1'b0;

        // Basic lookups at the corners of frame 0
        cyc(0, 0, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 1, 31, 31, 0);
        cyc(0, 0, 0, 0, 5, 5, 0);
        for (int i = 0; i < 20; i++)
            cyc(0, 0, 0, 1, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), 1'($urandom));

        // Loop mode: 40 ticks, one idle cycle between ticks
        cyc(0, 1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 40; i++) begin
            cyc(1, 1, 0, 1, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), 1'($urandom));
            cyc(0, 1, 0, 1, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), 1'($urandom));
        end

        // Ping-pong with HOLD=1 against the literal expected order
        cyc(0, 1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            cyc(1, 1, 0, 1, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), 1'b0);
            check("pingpong_order", 32'(f1), pp_seq[i]);
        end

        // Restart and tick together at frame 2
        cyc(0, 1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 16; i++)
            cyc(1, 1, 0, 0, 0, 0, 0);
        check("at_frame2", 32'(f0), 2);
        cyc(1, 1, 1, 1, 3, 4, 0);
        check("restart_priority", 32'(f0), 0);
        for (int i = 0; i < 8; i++)
            cyc(1, 1, 0, 1, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), 1'b0);

        // Pause keeps count and frame; resume continues from the held count
        cyc(0, 1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++)
            cyc(1, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++)
            cyc(1, 0, 0, 1, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), 1'b0);
        for (int i = 0; i < 5; i++)
            cyc(1, 1, 0, 0, 0, 0, 0);
        check("resume_advance", 32'(f0), 1);
        cyc(0, 0, 1, 0, 0, 0, 0);
        check("restart_paused", 32'(f0), 0);

        // Mirror and out-of-range columns
        cyc(0, 0, 0, 1, 0, 7, 1);
        cyc(0, 0, 0, 1, 0, 7, 0);
        cyc(0, 0, 0, 1, 31, 3, 0);
        cyc(0, 0, 0, 1, 30, 9, 1);
        cyc(0, 0, 0, 1, 29, 9, 1);

        // Randomised mix of ticks, pauses, restarts and lookups
        for (int i = 0; i < 400; i++)
            cyc(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 4) != 0),
                1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 3) != 0),
                int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), 1'($urandom));

        // Reset asserted mid-stream clears outputs without a clock edge
        drive_bus(1'b1, 4, 4, 1'b0);
        rst = 1'b1;
        #1;
        check_cleared("async_reset");
        #2;
        rst = 1'b0;
        t0 = 0;
        t1 = 0;
        exp0 = 0;
        exp1 = 0;
        exp2 = 0;
        cyc(0, 1, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 1, 12, 20, 0);
        for (int i = 0; i < 30; i++)
            cyc(1, 1, 0, 1, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), 1'($urandom));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
